ysyx_22040729_div_seq: RTL and testbench



---
 rtl/ysyx_22040729_mdu_pkg.sv | 25 ++
 rtl/ysyx_22040729_div_step.sv | 29 ++
 rtl/ysyx_22040729_div_seq.sv | 155 +++++++++++++++
 tb/tb_ysyx_22040729_div_seq.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22040729_mdu_pkg.sv
// Shared definitions for the RV64M multiply/divide unit.
// Holds the func3 encodings of the divide family, the divide sequencer
// state encoding and the iteration counter width helper.
package ysyx_22040729_mdu_pkg;

  localparam logic [2:0] DIV_F3  = 3'b100;
  localparam logic [2:0] DIVU_F3 = 3'b101;
  localparam logic [2:0] REM_F3  = 3'b110;
  localparam logic [2:0] REMU_F3 = 3'b111;

  localparam int MDU_XLEN = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;

  // Bits needed to count DATA_WIDTH iterations down to zero.
  function automatic int cnt_width(input int data_width);
    return $clog2(data_width);
  endfunction

endpackage

// File: rtl/ysyx_22040729_div_step.sv
// One restoring-division iteration, purely combinational.
// Ports:
//   rem      current partial remainder (always < dvs)
//   quo      current dividend/quotient shift register
//   dvs      divisor magnitude
//   rem_nxt  partial remainder after this iteration
//   quo_nxt  shift register after this iteration, new quotient bit in bit 0
module ysyx_22040729_div_step #(
  parameter int DATA_WIDTH = 64
) (
  input  logic [DATA_WIDTH-1:0] rem,
  input  logic [DATA_WIDTH-1:0] quo,
  input  logic [DATA_WIDTH-1:0] dvs,
  output logic [DATA_WIDTH-1:0] rem_nxt,
  output logic [DATA_WIDTH-1:0] quo_nxt
);

  // Shifted remainder needs one extra bit: it can reach 2*dvs-1.
  logic [DATA_WIDTH:0] rem_sh;
  logic                ge;

  assign rem_sh = {rem, quo[DATA_WIDTH-1]};
  // Comparing on the widened value is the sign test of the trial subtraction;
  // when it succeeds the difference is below dvs, so the low bits suffice.
  assign ge      = (rem_sh >= {1'b0, dvs});
  assign rem_nxt = ge ? (rem_sh[DATA_WIDTH-1:0] - dvs) : rem_sh[DATA_WIDTH-1:0];
  assign quo_nxt = {quo[DATA_WIDTH-2:0], ge};

endmodule

// File: rtl/ysyx_22040729_div_seq.sv
// Multi-cycle RV64M divide/remainder sequencer (DIV/DIVU/REM/REMU and W forms).
// Restoring shift-subtract, one quotient bit per cycle, RISC-V results for
// divide-by-zero and signed overflow.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   flush               abort any in-flight op, return to IDLE
//   in_valid/in_ready   request handshake (src1, src2, func3, is_w)
//   out_valid/out_ready result handshake (result)
//   busy                sequencer not idle
module ysyx_22040729_div_seq
  import ysyx_22040729_mdu_pkg::*;
#(
  parameter int DATA_WIDTH = MDU_XLEN
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] src1,
  input  logic [DATA_WIDTH-1:0] src2,
  input  logic [2:0]            func3,
  input  logic                  is_w,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  busy
);

  localparam int HW    = DATA_WIDTH / 2;
  localparam int CNT_W = cnt_width(DATA_WIDTH);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HW - 1);

  function automatic logic [DATA_WIDTH-1:0] sext_half(input logic [HW-1:0] v);
    return {{HW{v[HW-1]}}, v};
  endfunction

  // W results are always the sign-extended low half.
  function automatic logic [DATA_WIDTH-1:0] fix_w(input logic w,
                                                  input logic [DATA_WIDTH-1:0] v);
    return w ? sext_half(v[HW-1:0]) : v;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] cond_neg(input logic neg,
                                                     input logic [DATA_WIDTH-1:0] v);
    return neg ? (~v + 1'b1) : v;
  endfunction

  div_state_e            state, state_nxt;
  logic [CNT_W-1:0]      cnt;
  logic [DATA_WIDTH-1:0] rem_q, quo_q, dvs_q, result_q;
  logic                  neg_q, neg_r, op_rem_q, is_w_q;
  logic [DATA_WIDTH-1:0] rem_nxt, quo_nxt;

  // Operand preparation for the request currently on the inputs.
  logic                  op_signed, op_rem, sign1, sign2;
  logic                  div_zero, ovf, special, accept;
  logic [DATA_WIDTH-1:0] a_ext, b_ext, mag_a, mag_b, min_val, special_val, quo_init;

  always_comb begin
    op_signed = (func3 == DIV_F3) || (func3 == REM_F3);
    op_rem    = (func3 == REM_F3) || (func3 == REMU_F3);
    a_ext     = src1;
    b_ext     = src2;
    if (is_w) begin
      a_ext = op_signed ? sext_half(src1[HW-1:0]) : {{HW{1'b0}}, src1[HW-1:0]};
      b_ext = op_signed ? sext_half(src2[HW-1:0]) : {{HW{1'b0}}, src2[HW-1:0]};
    end
    sign1   = op_signed & a_ext[DATA_WIDTH-1];
    sign2   = op_signed & b_ext[DATA_WIDTH-1];
    mag_a   = cond_neg(sign1, a_ext);
    mag_b   = cond_neg(sign2, b_ext);
    min_val = is_w ? sext_half({1'b1, {(HW-1){1'b0}}}) : {1'b1, {(DATA_WIDTH-1){1'b0}}};

    div_zero = (b_ext == '0);
    ovf      = op_signed && (a_ext == min_val) && (b_ext == '1);
    special  = div_zero || ovf;
    if (div_zero)
      special_val = op_rem ? a_ext : '1;
    else
      special_val = op_rem ? '0 : a_ext;

    // W ops park the 32-bit magnitude in the upper half so that 32 shifts
    // consume exactly those bits and leave the quotient in the low half.
    quo_init = is_w ? {mag_a[HW-1:0], {HW{1'b0}}} : mag_a;

    accept = (state == IDLE) && in_valid && !flush;
  end

  ysyx_22040729_div_step #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_step (
    .rem    (rem_q),
    .quo    (quo_q),
    .dvs    (dvs_q),
    .rem_nxt(rem_nxt),
    .quo_nxt(quo_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = special ? DONE : CALC;
      CALC: if (cnt == '0) state_nxt = FIX;
      FIX:  state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      result_q <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      op_rem_q <= 1'b0;
      is_w_q   <= 1'b0;
    end else if (accept) begin
      cnt      <= is_w ? CNT_HALF : CNT_FULL;
      rem_q    <= '0;
      quo_q    <= quo_init;
      dvs_q    <= mag_b;
      neg_q    <= sign1 ^ sign2;
      neg_r    <= sign1;
      op_rem_q <= op_rem;
      is_w_q   <= is_w;
      if (special) result_q <= fix_w(is_w, special_val);
    end else if (!flush && state == CALC) begin
      // iteration stage
      rem_q <= rem_nxt;
      quo_q <= quo_nxt;
      cnt   <= cnt - CNT_W'(1);
    end else if (!flush && state == FIX) begin
      // sign correction / W extension stage
      result_q <= fix_w(is_w_q, op_rem_q ? cond_neg(neg_r, rem_q) : cond_neg(neg_q, quo_q));
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign result    = result_q;

endmodule

// File: tb/tb_ysyx_22040729_div_seq.sv
module tb_ysyx_22040729_div_seq;
  import ysyx_22040729_mdu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] src1 = '0;
  logic [63:0] src2 = '0;
  logic [2:0]  func3 = DIV_F3;
  logic        is_w = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] result;
  logic        busy;

  ysyx_22040729_div_seq #(.DATA_WIDTH(64)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .src1     (src1),
    .src2     (src2),
    .func3    (func3),
    .is_w     (is_w),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] res;
    int          lat;   // edges from accept edge to the edge that raises out_valid
    int          acc;
    int          id;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Monitor: latency measured from accept to out_valid rise, value at handshake.
  task automatic monitor();
    logic prev_ov = 1'b0;
    int   rise = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (out_valid && !prev_ov) rise = cyc;
      if (out_valid && out_ready && !flush) begin
        if (sb.size() == 0) begin
          chk("unexpected_out_valid", {63'd0, out_valid}, 64'd0);
        end else begin
          e = sb.pop_front();
          chk($sformatf("result_op%0d", e.id), result, e.res);
          chk($sformatf("latency_op%0d", e.id), 64'(rise - e.acc), 64'(e.lat));
        end
      end
      prev_ov = out_valid;
    end
  endtask

  // Called in the phase just after a rising edge.
  task automatic issue(input int id, input logic [2:0] f3, input logic w,
                       input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] exp, input int lat, input bit push);
    exp_t e;
    int   n = 0;
    while (!in_ready && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      chk($sformatf("in_ready_timeout_op%0d", id), 64'd0, 64'd1);
      return;
    end
    func3 = f3; is_w = w; src1 = a; src2 = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (push) begin
      e.res = exp; e.lat = lat; e.acc = cyc; e.id = id;
      sb.push_back(e);
    end
  endtask

  task automatic cycles(input int k);
    repeat (k) begin @(posedge clk); #1; end
  endtask

  initial begin
    int n;
    fork
      monitor();
    join_none

    #1;
    chk("reset_in_ready", {63'd0, in_ready}, 64'd1);
    chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_result", result, 64'd0);
    cycles(2);
    rst_n = 1'b1;
    cycles(1);

    // Full-width signed / unsigned
    issue(1, DIV_F3,  1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,  64'hFFFF_FFFF_FFFF_FFFD, 65, 1);
    issue(2, REM_F3,  1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,  64'hFFFF_FFFF_FFFF_FFFF, 65, 1);
    issue(3, DIVU_F3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h10, 64'h0FFF_FFFF_FFFF_FFFF, 65, 1);
    issue(4, REMU_F3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h10, 64'hF, 65, 1);
    issue(5, REM_F3,  1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 65, 1);
    // W variants, overflow and normal
    issue(6, DIV_F3,  1'b1, 64'h1_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 0, 1);
    issue(7, REM_F3,  1'b1, 64'h1_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 0, 1);
    issue(8, DIVU_F3, 1'b1, 64'hFFFF_FFFE, 64'd1, 64'hFFFF_FFFF_FFFF_FFFE, 33, 1);
    issue(9, DIV_F3,  1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 33, 1);
    issue(10, REM_F3, 1'b1, 64'd7, 64'hFFFF_FFFE, 64'd1, 33, 1);
    // Divide by zero, full-width overflow
    issue(11, DIV_F3,  1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1);
    issue(12, REMU_F3, 1'b0, 64'h1234, 64'd0, 64'h1234, 0, 1);
    issue(13, DIV_F3,  1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
          64'h8000_0000_0000_0000, 0, 1);

    // Flush in CALC: op is dropped, next op accepted the cycle after
    issue(14, DIV_F3, 1'b0, 64'd1000, 64'd3, 64'd0, 0, 0);
    cycles(9);
    flush = 1'b1;
    cycles(1);
    flush = 1'b0;
    chk("flush_busy", {63'd0, busy}, 64'd0);
    chk("flush_out_valid", {63'd0, out_valid}, 64'd0);
    chk("flush_in_ready", {63'd0, in_ready}, 64'd1);
    issue(15, DIVU_F3, 1'b0, 64'd100, 64'd7, 64'd14, 65, 1);

    // Flush with in_valid in IDLE must not accept
    n = 0;
    while (!in_ready && n < 300) begin cycles(1); n++; end
    flush = 1'b1; in_valid = 1'b1; func3 = DIVU_F3; src1 = 64'd9; src2 = 64'd3;
    cycles(1);
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_idle_no_accept", {63'd0, busy}, 64'd0);

    // Consumer backpressure in DONE
    out_ready = 1'b0;
    issue(16, DIVU_F3, 1'b0, 64'd1000, 64'd10, 64'd100, 65, 1);
    n = 0;
    while (!out_valid && n < 300) begin cycles(1); n++; end
    chk("hold_out_valid_seen", {63'd0, out_valid}, 64'd1);
    for (int i = 0; i < 5; i++) begin
      chk("hold_result", result, 64'd100);
      chk("hold_in_ready", {63'd0, in_ready}, 64'd0);
      cycles(1);
    end
    chk("hold_out_valid", {63'd0, out_valid}, 64'd1);
    out_ready = 1'b1;
    cycles(1);
    chk("release_in_ready", {63'd0, in_ready}, 64'd1);
    chk("release_out_valid", {63'd0, out_valid}, 64'd0);

    // Asynchronous reset in CALC
    issue(17, DIV_F3, 1'b0, 64'd77, 64'd5, 64'd0, 0, 0);
    cycles(5);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_in_ready", {63'd0, in_ready}, 64'd1);
    chk("midreset_out_valid", {63'd0, out_valid}, 64'd0);
    chk("midreset_busy", {63'd0, busy}, 64'd0);
    chk("midreset_result", result, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    cycles(1);
    issue(18, DIVU_F3, 1'b0, 64'd100, 64'd7, 64'd14, 65, 1);

    n = 0;
    while (sb.size() != 0 && n < 300) begin cycles(1); n++; end
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    cycles(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
